div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Sequences the shared 32-bit subtract unit to perform iterative restoring division for the ALU's DIV operation.
- Takes dividend and divisor on a start pulse and drives the subtractor's A/B inputs once per cycle.
- Samples the subtractor's difference and carry-out, and returns quotient and remainder with a one-cycle done pulse.
- Sits between the control unit (start/done handshake) and the combinational subtract unit; the subtract unit stays outside this block.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  synchronous active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  32  numerator, captured on the accepted start edge.
- divisor  input  32  denominator, captured on the accepted start edge.
- signed_op  input  1  signed division request; used only with SIGNED_DIV_EN.
- sub_a  output  32  subtractor minuend; combinational from internal registers.
- sub_b  output  32  subtractor subtrahend; equals the captured divisor magnitude.
- sub_diff  input  32  subtractor difference (sub_a - sub_b).
- sub_cout  input  1  subtractor carry-out; 1 means sub_a >= sub_b (valid for sub_b != 0).
- busy  output  1  high from the edge after start acceptance until DONE exits.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  32  result quotient.
- remainder  output  32  result remainder.
- div_by_zero  output  1  set with done when the divisor is 0.

Behaviour:
- Clock and reset: one clock, `clock`; `clear` is synchronous, active-high, and has priority over all other inputs.
- Reset values: state=IDLE; busy, done and div_by_zero = 0; quotient, remainder, sub_a and sub_b = 0; iteration counter = 0.
- States and transitions:
  - IDLE: start=1 and divisor!=0 -> ITER; start=1 and divisor==0 -> DONE.
  - ITER: stays for exactly WIDTH cycles -> FIX if signed feature active, else -> DONE.
  - FIX: one cycle -> DONE.
  - DONE: one cycle -> IDLE.
- Start acceptance (edge 0): capture the divisor (magnitude) into dreg; quo <= dividend (magnitude); rem <= 0; cnt <= 0.
- ITER, each cycle:
  - shifted = {rem[30:0], quo[31]}; sub_a = shifted; sub_b = dreg.
  - take = rem[31] | sub_cout. rem[31] covers the 33-bit case where the shifted value exceeds 32 bits.
  - If take: rem <= sub_diff; quo <= {quo[30:0], 1}.
  - Else: rem <= shifted; quo <= {quo[30:0], 0}.
  - cnt increments; leave ITER when cnt == WIDTH-1 at the edge.
- Outside ITER: sub_a = 0 and sub_b = 0.
- The subtractor is never driven with sub_b = 0 during ITER, because the divide-by-zero path bypasses ITER entirely.
- Latency, counted from the start-sampling edge:
  - Unsigned: done high in the cycle after edge 32.
  - Signed (feature on): done after edge 33.
  - Divide-by-zero: done after edge 1.
- Divide-by-zero results: quotient = 32'hFFFFFFFF, remainder = dividend, div_by_zero = 1.
- Result hold: quotient, remainder and div_by_zero load on DONE entry and hold until the next accepted start.
- On the next accepted start, div_by_zero clears; quotient and remainder keep their old values until the new DONE.
- Start while busy (ITER/FIX/DONE) is ignored; no queuing.
- Start held high continuously: re-accepted in the first IDLE cycle after DONE.
- Clear mid-operation: IDLE on the next edge; all outputs return to reset values and no done pulse is issued.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- With the macro, when signed_op=1 at start acceptance:
  - Capture |dividend| and |divisor| (two's-complement negate if the MSB is set).
  - Record the sign flags.
  - FIX negates the quotient if the signs differ, and negates the remainder if the dividend was negative.
- With the macro, all operations pass through FIX (uniform 33-edge latency).
- With the macro, 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0, no flag.
- With the macro, signed divide-by-zero gives the same results as unsigned divide-by-zero.
- Without the macro: signed_op is ignored, the FIX state is absent, and all division is unsigned with 32-edge latency.

Test Plan:
- dividend=100, divisor=7, start 1 cycle -> busy next cycle; done after edge 32 (unsigned); quotient=14, remainder=2, div_by_zero=0.
- dividend=32'hFFFFFFFE, divisor=32'h80000001 -> quotient=1, remainder=32'h7FFFFFFD (exercises the rem[31] take path); 32'hFFFFFFFF/1 -> quotient=32'hFFFFFFFF, remainder=0.
- dividend=5, divisor=0 -> done after edge 1; quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1; sub_b stays 0 throughout.
- Start 100/7, re-pulse start with 9/3 at edge 5, then clear at edge 10 -> the second start has no effect; after the clear edge busy=0, outputs are 0 and no done pulse occurs; a fresh 9/3 then gives quotient=3, remainder=0.
- SIGNED_DIV_EN on, signed_op=1, -7/2 (32'hFFFFFFF9 / 2) -> after edge 33, quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF. Macro off, same stimulus -> quotient=32'h7FFFFFFC, remainder=1 after edge 32.
- Back-to-back: start held high for 100/7 then 50/5 -> two done pulses separated by one IDLE cycle; results 14/2, then 10/0.

Source files
------------

// File: rtl/div_sequencer.sv
// Iterative restoring divider that sequences an external 32-bit subtract unit.
// Optional signed division is enabled by defining SIGNED_DIV_EN.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    ZERO,
`ifdef SIGNED_DIV_EN
    FIX,
`endif
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dreg;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifted;
  logic             take;
  logic [WIDTH-1:0] nextQuo;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic             dividendNeg;
  logic             divisorNeg;

`ifdef SIGNED_DIV_EN
  logic negQuo;
  logic negRem;

  assign dividendNeg = signed_op & dividend[WIDTH-1];
  assign divisorNeg  = signed_op & divisor[WIDTH-1];
`else
  logic unusedSignedOp;

  assign unusedSignedOp = signed_op;
  assign dividendNeg    = 1'b0;
  assign divisorNeg     = 1'b0;
`endif

  assign dividendMag = dividendNeg ? -dividend : dividend;
  assign divisorMag  = divisorNeg ? -divisor : divisor;

  // rem[MSB] set means the shifted partial remainder needs WIDTH+1 bits and always exceeds dreg
  assign shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign take    = rem[WIDTH-1] | sub_cout;
  assign nextQuo = {quo[WIDTH-2:0], take};
  assign nextRem = take ? sub_diff : shifted;

  assign sub_a = (state == ITER) ? shifted : '0;
  assign sub_b = (state == ITER) ? dreg : '0;

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      dreg        <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            if (divisor == '0) begin
              // Zero divisor skips ITER; ZERO supplies the single-cycle delay before done
              rem   <= dividend;
              state <= ZERO;
            end else begin
              dreg  <= divisorMag;
              quo   <= dividendMag;
              rem   <= '0;
              state <= ITER;
`ifdef SIGNED_DIV_EN
              negQuo <= dividendNeg ^ divisorNeg;
              negRem <= dividendNeg;
`endif
            end
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          quo <= nextQuo;
          rem <= nextRem;
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIGNED_DIV_EN
            state <= FIX;
`else
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= nextQuo;
            remainder <= nextRem;
`endif
          end
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          quotient  <= negQuo ? -quo : quo;
          remainder <= negRem ? -rem : rem;
          done      <= 1'b1;
          state     <= DONE;
        end
`endif
        ZERO: begin
          quotient    <= '1;
          remainder   <= rem;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with a behavioural subtract unit.
module tb_div_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        signedOp;
  logic [31:0] subA;
  logic [31:0] subB;
  logic [31:0] subDiff;
  logic        subCout;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  int vectors = 0;
  int miscompares = 0;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  div_sequencer #(.WIDTH(32)) dut (
    .clock(clock),
    .clear(clear),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .signed_op(signedOp),
    .sub_a(subA),
    .sub_b(subB),
    .sub_diff(subDiff),
    .sub_cout(subCout),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(divByZero)
  );

  assign subDiff = subA - subB;
  assign subCout = (subA >= subB);

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one edge, wait for done, check latency and results.
  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [31:0] expQ, input logic [31:0] expR,
                        input logic expZ, input int lat);
    int n;
    logic subBSeen;
    dividend = a;
    divisor  = b;
    signedOp = sgn;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    subBSeen = 1'b0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (subB != 32'd0) subBSeen = 1'b1;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " quotient"}, quotient, expQ);
    chk({tag, " remainder"}, remainder, expR);
    chk({tag, " div_by_zero"}, {31'd0, divByZero}, {31'd0, expZ});
    if (b == 32'd0) chk({tag, " sub_b zero"}, {31'd0, subBSeen}, 32'd0);
    tick();
    chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " hold quotient"}, quotient, expQ);
  endtask

  initial begin
    int n;
    logic sawDone;
    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    signedOp = 1'b0;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dbz", {31'd0, divByZero}, 32'd0);
    chk("reset sub_a", subA, 32'd0);
    chk("reset sub_b", subB, 32'd0);
    clear = 1'b0;
    tick();

    runDiv("100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT);
    runDiv("big/big", 32'hFFFFFFFE, 32'h80000001, 1'b0, 32'd1, 32'h7FFFFFFD, 1'b0, LAT);
    runDiv("max/1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, LAT);
    runDiv("5/0", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 1);

    // Start while busy is ignored; clear aborts without a done pulse.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("abort dbz cleared", {31'd0, divByZero}, 32'd0);
    sawDone = 1'b0;
    repeat (4) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    if (done) sawDone = 1'b1;
    repeat (4) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    chk("abort still busy", {31'd0, busy}, 32'd1);
    chk("abort old quotient", quotient, 32'hFFFFFFFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    chk("abort sub_a", subA, 32'd0);
    repeat (40) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    chk("abort no done", {31'd0, sawDone}, 32'd0);
    runDiv("9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, LAT);

`ifdef SIGNED_DIV_EN
    runDiv("-7/2 s", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    runDiv("min/-1 s", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 33);
    runDiv("-5/0 s", 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1);
`else
    runDiv("-7/2 u", 32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0, 32);
`endif

    // Back-to-back with start held high.
    dividend = 32'd100;
    divisor  = 32'd7;
    signedOp = 1'b0;
    start    = 1'b1;
    tick();
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("b2b first latency", n, LAT);
    chk("b2b first quotient", quotient, 32'd14);
    chk("b2b first remainder", remainder, 32'd2);
    dividend = 32'd50;
    divisor  = 32'd5;
    tick();
    chk("b2b idle done", {31'd0, done}, 32'd0);
    chk("b2b idle busy", {31'd0, busy}, 32'd0);
    tick();
    chk("b2b reaccept busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("b2b second latency", n, LAT);
    chk("b2b second quotient", quotient, 32'd10);
    chk("b2b second remainder", remainder, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
